// File: rtl/shift_ctrl_pkg.sv
// Shared types and default sizing for the parallel-in/serial-out controller.
package shift_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Load handshake, serial output stream and status of the serialiser.
interface shift_seq_ctrl_if #(
  parameter int unsigned WIDTH = shift_ctrl_pkg::DEF_WIDTH,
  parameter int unsigned CNT_W = shift_ctrl_pkg::DEF_CNT_W
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_ready;
  logic             abort;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output in_valid, in_data, out_ready, abort,
    input  in_ready, sout, sout_valid, sout_last, busy, word_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, abort,
    output in_ready, sout, sout_valid, sout_last, busy, word_cnt
  );
endinterface

// File: rtl/piso_core.sv
// Parallel-load shift register with MSB tap; clear beats load beats shift.
module piso_core #(
  parameter int unsigned WIDTH = shift_ctrl_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] sreg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          sreg_q <= '0;
    else if (clear)    sreg_q <= '0;
    else if (load)     sreg_q <= din;
    else if (shift_en) sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
  end

  assign msb = sreg_q[WIDTH-1];
endmodule

// File: rtl/shift_seq_ctrl.sv
// Serialises parallel words MSB first with zero-bubble reload, stall, abort
// and a wrapping count of completed words.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = shift_ctrl_pkg::DEF_WIDTH,
  parameter int unsigned CNT_W = shift_ctrl_pkg::DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  shift_seq_ctrl_if.slave bus
);
  import shift_ctrl_pkg::*;

  localparam int unsigned BW = $clog2(WIDTH);

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] word_cnt_q;
  logic            rst_meta_q, rst_ok_q;
  logic            shifting, last_bit, accept, xfer;
  logic            load, shift_en, clear, word_done;
  logic            msb;

  // Reset release is synchronised before the handshake may open
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_ok_q   <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_ok_q   <= rst_meta_q;
    end
  end

  assign shifting = (state_q == SHIFT);
  assign last_bit = shifting && (bit_cnt_q == '0);
  assign xfer     = shifting && bus.out_ready && !bus.abort;

  assign bus.in_ready   = rst_ok_q && !bus.abort &&
                          (!shifting || (last_bit && bus.out_ready));
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.sout       = shifting && msb;
  assign bus.sout_valid = shifting;
  assign bus.sout_last  = last_bit;
  assign bus.busy       = shifting;
  assign bus.word_cnt   = word_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      if (word_done) word_cnt_q <= word_cnt_q + CNT_W'(1);
    end
  end

  // Next state and datapath controls; abort overrides everything
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    clear     = 1'b0;
    word_done = 1'b0;
    if (bus.abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      clear     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = SHIFT;
            bit_cnt_d = BW'(WIDTH - 1);
            load      = 1'b1;
          end
        end
        SHIFT: begin
          if (xfer) begin
            shift_en = 1'b1;
            if (last_bit) begin
              word_done = 1'b1;
              if (accept) begin
                bit_cnt_d = BW'(WIDTH - 1);
                load      = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - BW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  piso_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .clear    (clear),
    .din      (bus.in_data),
    .msb      (msb)
  );
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, shift-register word width in bits (WIDTH >= 2).
REQ-002 Parameter CNT_W, default 8, width of the completed-word counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer has a parallel word on in_data.
REQ-006 in_data  input  WIDTH  parallel word to serialise, MSB sent first.
REQ-007 in_ready  output  1  controller can accept a word this cycle.
REQ-008 out_ready  input  1  serial sink accepts the current bit this cycle.
REQ-009 abort  input  1  synchronous flush request.
REQ-010 sout  output  1  current serial bit.
REQ-011 sout_valid  output  1  sout is valid.
REQ-012 sout_last  output  1  sout is the final (LSB) bit of the word.
REQ-013 busy  output  1  a word is being shifted out.
REQ-014 word_cnt  output  CNT_W  count of fully transmitted words.

Function
REQ-015 FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-016 Load handshake: a word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-017 On accept: in_data captured into shift register, bit counter set to WIDTH-1, state -> SHIFT.
REQ-018 in_ready SHALL be 1 in IDLE, 1 in SHIFT only when sout_last=1 and out_ready=1 (zero-bubble reload), else 0.
REQ-019 In SHIFT: sout = shift register MSB, sout_valid=1, sout_last=1 iff bit counter = 0, busy=1.
REQ-020 Bit transfer: an edge with sout_valid=1 and out_ready=1 SHALL shift the register left by one (LSB filled with 0) and decrement the bit counter.
REQ-021 out_ready=0 in SHIFT: register, counter, state held unchanged (stall, no bit lost or duplicated).
REQ-022 Last-bit transfer: word_cnt SHALL increment by 1 (wraps modulo 2^CNT_W); state -> SHIFT with new word if a word is accepted in the same edge, else -> IDLE.
REQ-023 Latency: first bit valid the cycle after accept; WIDTH cycles per word with out_ready held 1; back-to-back words SHALL have no idle cycle.
REQ-024 In IDLE: sout=0, sout_valid=0, sout_last=0, busy=0.
REQ-025 abort=1 at an edge: state -> IDLE, shift register and bit counter cleared, word_cnt unchanged; abort SHALL take priority over accept and bit transfer; in_ready SHALL be 0 while abort=1.
REQ-026 in_valid while in_ready=0 SHALL be ignored; in_data SHALL only be sampled on accept.

Reset
REQ-027 rst=0 SHALL immediately (asynchronously) force IDLE, shift register=0, bit counter=0, word_cnt=0.
REQ-028 During reset outputs: in_ready=0, sout=0, sout_valid=0, sout_last=0, busy=0.
REQ-029 Reset deassertion SHALL be synchronised; in_ready=1 no earlier than the first edge after release.
REQ-030 Reset mid-word SHALL discard the partial word with no word_cnt increment.

Structure
REQ-031 Package shift_ctrl_pkg SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH/CNT_W constants.
REQ-032 The load/shift datapath SHALL be one sub-module, piso_core (load, shift_en, clear -> WIDTH register, MSB tap); the FSM, bit counter and word_cnt stay in shift_seq_ctrl.

Verification (WIDTH=4)
REQ-033 Single word: in_data=1100 accepted, out_ready=1 -> sout 1,1,0,0 on four consecutive cycles, sout_last on 4th only, word_cnt=1, then IDLE.
REQ-034 Back-to-back: 1101 then 0100 with in_valid held -> eight consecutive valid bits 1,1,0,1,0,1,0,0, second accept on the last-bit edge of the first, word_cnt=2.
REQ-035 Stall: word 0011, out_ready=0 for 3 cycles after the first bit -> sout held 0 with sout_valid=1, sequence 0,0,1,1 intact, word_cnt=1.
REQ-036 Abort: word 1111, abort after 2 bits -> next cycle IDLE, sout_valid=0, word_cnt unchanged; next word 1110 serialises correctly.
REQ-037 Reset mid-word: rst=0 after 1 bit of 1100 -> outputs zero immediately, word_cnt=0; after release 0100 serialises correctly.
REQ-038 Wrap: CNT_W=2, send 5 words -> word_cnt sequence 1,2,3,0,1.
